// File: rtl/scr1_dbgc_hart_seq_if.sv
// Host-command and hart DBGA signal bundle for the DBGC hart sequencer.
// slave = the sequencer itself, master = the host front-end plus hart agent it talks to.
interface scr1_dbgc_hart_seq_if;
    logic        host_cmd_vld;
    logic [1:0]  host_cmd;
    logic [31:0] host_instr;
    logic [31:0] host_ddr_wdata;
    logic        host_irq_dsbl;
    logic        host_cmd_rdy;
    logic        host_rsp_vld;
    logic [1:0]  host_rsp_status;
    logic [31:0] host_rsp_ddr;
    logic        hart_cmd;
    logic        hart_cmd_req;
    logic        hart_cmd_ack;
    logic        hart_cmd_nack;
    logic        hart_halted;
    logic        hart_except;
    logic        hart_fetch_dbgc;
    logic        hart_sstep_en;
    logic        hart_irq_dsbl;
    logic [31:0] hart_instr;
    logic [31:0] hart_dreg_out;
    logic [31:0] hart_dreg_in;
    logic        hart_dreg_wr;

    modport master (
        output host_cmd_vld, host_cmd, host_instr, host_ddr_wdata, host_irq_dsbl,
               hart_cmd_ack, hart_cmd_nack, hart_halted, hart_except, hart_dreg_in, hart_dreg_wr,
        input  host_cmd_rdy, host_rsp_vld, host_rsp_status, host_rsp_ddr,
               hart_cmd, hart_cmd_req, hart_fetch_dbgc, hart_sstep_en, hart_irq_dsbl,
               hart_instr, hart_dreg_out
    );

    modport slave (
        input  host_cmd_vld, host_cmd, host_instr, host_ddr_wdata, host_irq_dsbl,
               hart_cmd_ack, hart_cmd_nack, hart_halted, hart_except, hart_dreg_in, hart_dreg_wr,
        output host_cmd_rdy, host_rsp_vld, host_rsp_status, host_rsp_ddr,
               hart_cmd, hart_cmd_req, hart_fetch_dbgc, hart_sstep_en, hart_irq_dsbl,
               hart_instr, hart_dreg_out
    );
endinterface

// File: rtl/scr1_dbgc_hart_seq.sv
// DBGC sequencer: turns host HALT/RESUME/STEP/EXEC commands into the hart DBGA handshake.
// Optional run timeout with forced halt is enabled by defining SCR1_DBGC_SEQ_TIMEOUT_EN.
module scr1_dbgc_hart_seq #(
    parameter int RUN_TIMEOUT = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    scr1_dbgc_hart_seq_if.slave      bus
);
    localparam logic [1:0] CMD_HALT = 2'd0, CMD_STEP = 2'd2, CMD_EXEC = 2'd3;
    localparam logic [1:0] RSP_OK = 2'd0, RSP_NACK = 2'd1, RSP_TIMEOUT = 2'd2, RSP_EXC = 2'd3;

    if (RUN_TIMEOUT < 4 || (RUN_TIMEOUT & (RUN_TIMEOUT - 1)) != 0) begin : g_bad_timeout
        $error("RUN_TIMEOUT must be a power of two and at least 4");
    end

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_RUN_WAIT, ST_FORCE_HALT, ST_RESP
    } state_e;

    state_e      state, state_nxt;
    logic [1:0]  cmd_q, cmd_nxt;
    logic        seen_run, seen_run_nxt;
    logic        rdy_q, rdy_nxt, rsp_vld_q, rsp_vld_nxt;
    logic [1:0]  status_q, status_nxt;
    logic [31:0] rsp_ddr_q, rsp_ddr_nxt;
    logic        hcmd_q, hcmd_nxt, req_q, req_nxt;
    logic        fetch_q, fetch_nxt, sstep_q, sstep_nxt, irq_q, irq_nxt;
    logic [31:0] instr_q, instr_nxt, dreg_out_q, dreg_out_nxt;
    logic        accept, run_done;

`ifdef SCR1_DBGC_SEQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(RUN_TIMEOUT);
    logic [TMR_W-1:0] timer, timer_nxt;
`endif

    assign accept   = rdy_q & bus.host_cmd_vld;
    assign run_done = seen_run & bus.hart_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cmd_q      <= CMD_HALT;
            seen_run   <= 1'b0;
            rdy_q      <= 1'b1;
            rsp_vld_q  <= 1'b0;
            status_q   <= RSP_OK;
            rsp_ddr_q  <= '0;
            hcmd_q     <= 1'b0;
            req_q      <= 1'b0;
            fetch_q    <= 1'b0;
            sstep_q    <= 1'b0;
            irq_q      <= 1'b0;
            instr_q    <= '0;
            dreg_out_q <= '0;
`ifdef SCR1_DBGC_SEQ_TIMEOUT_EN
            timer      <= '0;
`endif
        end else begin
            state      <= state_nxt;
            cmd_q      <= cmd_nxt;
            seen_run   <= seen_run_nxt;
            rdy_q      <= rdy_nxt;
            rsp_vld_q  <= rsp_vld_nxt;
            status_q   <= status_nxt;
            rsp_ddr_q  <= rsp_ddr_nxt;
            hcmd_q     <= hcmd_nxt;
            req_q      <= req_nxt;
            fetch_q    <= fetch_nxt;
            sstep_q    <= sstep_nxt;
            irq_q      <= irq_nxt;
            instr_q    <= instr_nxt;
            dreg_out_q <= dreg_out_nxt;
`ifdef SCR1_DBGC_SEQ_TIMEOUT_EN
            timer      <= timer_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (accept) state_nxt = ST_CMD;
            ST_CMD: begin
                if (bus.hart_cmd_ack)
                    state_nxt = (cmd_q == CMD_STEP || cmd_q == CMD_EXEC) ? ST_RUN_WAIT : ST_RESP;
                else if (bus.hart_cmd_nack)
                    state_nxt = ST_RESP;
            end
            ST_RUN_WAIT: begin
                if (run_done)
                    state_nxt = ST_RESP;
`ifdef SCR1_DBGC_SEQ_TIMEOUT_EN
                else if (timer == '0)
                    state_nxt = ST_FORCE_HALT;
`endif
            end
`ifdef SCR1_DBGC_SEQ_TIMEOUT_EN
            // req low here means the halt request has already been answered
            ST_FORCE_HALT: if (!req_q && bus.hart_halted) state_nxt = ST_RESP;
`endif
            ST_RESP:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_nxt      = cmd_q;
        seen_run_nxt = seen_run;
        rdy_nxt      = (state_nxt == ST_IDLE);
        rsp_vld_nxt  = (state_nxt == ST_RESP);
        status_nxt   = status_q;
        rsp_ddr_nxt  = bus.hart_dreg_wr ? bus.hart_dreg_in : rsp_ddr_q;
        hcmd_nxt     = hcmd_q;
        req_nxt      = req_q;
        fetch_nxt    = fetch_q;
        sstep_nxt    = sstep_q;
        irq_nxt      = irq_q;
        instr_nxt    = instr_q;
        dreg_out_nxt = dreg_out_q;
`ifdef SCR1_DBGC_SEQ_TIMEOUT_EN
        timer_nxt    = (state != ST_RUN_WAIT) ? TMR_W'(RUN_TIMEOUT - 1)
                     : (timer != '0)          ? timer - 1'b1 : timer;
`endif

        if (accept) begin
            cmd_nxt      = bus.host_cmd;
            hcmd_nxt     = (bus.host_cmd == CMD_HALT);
            req_nxt      = 1'b1;
            sstep_nxt    = (bus.host_cmd == CMD_STEP) || (bus.host_cmd == CMD_EXEC);
            fetch_nxt    = (bus.host_cmd == CMD_EXEC);
            irq_nxt      = bus.host_irq_dsbl;
            instr_nxt    = bus.host_instr;
            dreg_out_nxt = bus.host_ddr_wdata;
        end

        if ((state == ST_CMD || state == ST_FORCE_HALT) && (bus.hart_cmd_ack || bus.hart_cmd_nack))
            req_nxt = 1'b0;

        if (state == ST_CMD)
            seen_run_nxt = 1'b0;
        else if (state == ST_RUN_WAIT && !bus.hart_halted)
            seen_run_nxt = 1'b1;

        if (state == ST_RUN_WAIT && state_nxt == ST_FORCE_HALT) begin
            hcmd_nxt = 1'b1;
            req_nxt  = 1'b1;
        end

        if (state_nxt == ST_RESP && state != ST_RESP) begin
            case (state)
                ST_CMD:      status_nxt = bus.hart_cmd_ack ? RSP_OK : RSP_NACK;
                ST_RUN_WAIT: status_nxt = bus.hart_except ? RSP_EXC : RSP_OK;
                default:     status_nxt = RSP_TIMEOUT;
            endcase
        end

        // irq_dsbl deliberately survives the response; only the run-mode fields drop
        if (state == ST_RESP) begin
            sstep_nxt = 1'b0;
            fetch_nxt = 1'b0;
        end
    end

    assign bus.host_cmd_rdy    = rdy_q;
    assign bus.host_rsp_vld    = rsp_vld_q;
    assign bus.host_rsp_status = status_q;
    assign bus.host_rsp_ddr    = rsp_ddr_q;
    assign bus.hart_cmd        = hcmd_q;
    assign bus.hart_cmd_req    = req_q;
    assign bus.hart_fetch_dbgc = fetch_q;
    assign bus.hart_sstep_en   = sstep_q;
    assign bus.hart_irq_dsbl   = irq_q;
    assign bus.hart_instr      = instr_q;
    assign bus.hart_dreg_out   = dreg_out_q;
endmodule

// File: tb/tb_scr1_dbgc_hart_seq.sv
// Directed bench for scr1_dbgc_hart_seq; the hart agent is driven cycle by cycle from the stimulus.
module tb_scr1_dbgc_hart_seq;
    localparam logic [1:0] HALT = 2'd0, RESUME = 2'd1, STEP = 2'd2, EXEC = 2'd3;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    logic flag;

    scr1_dbgc_hart_seq_if bus ();

    scr1_dbgc_hart_seq #(.RUN_TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] c, input logic [31:0] ins, input logic [31:0] ddr,
                        input logic irq);
        bus.host_cmd_vld   = 1'b1;
        bus.host_cmd       = c;
        bus.host_instr     = ins;
        bus.host_ddr_wdata = ddr;
        bus.host_irq_dsbl  = irq;
        @(negedge clk);
        bus.host_cmd_vld   = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.host_cmd_vld = 1'b0;
        bus.host_cmd = HALT;
        bus.host_instr = '0;
        bus.host_ddr_wdata = '0;
        bus.host_irq_dsbl = 1'b0;
        bus.hart_cmd_ack = 1'b0;
        bus.hart_cmd_nack = 1'b0;
        bus.hart_halted = 1'b0;
        bus.hart_except = 1'b0;
        bus.hart_dreg_in = '0;
        bus.hart_dreg_wr = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_rdy", bus.host_cmd_rdy, 1);
        chk("rst_rsp_vld", bus.host_rsp_vld, 0);
        chk("rst_status", bus.host_rsp_status, 0);
        chk("rst_rsp_ddr", bus.host_rsp_ddr, 0);
        chk("rst_req", bus.hart_cmd_req, 0);
        chk("rst_hart_cmd", bus.hart_cmd, 0);
        chk("rst_runctrl", {bus.hart_fetch_dbgc, bus.hart_sstep_en, bus.hart_irq_dsbl}, 0);
        chk("rst_instr", bus.hart_instr, 0);
        chk("rst_dreg_out", bus.hart_dreg_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // HALT on a running hart, acked in the third request cycle
        send(HALT, 32'h0, 32'h0, 1'b0);
        chk("t1_req_c1", bus.hart_cmd_req, 1);
        chk("t1_rdy_busy", bus.host_cmd_rdy, 0);
        chk("t1_hart_cmd", bus.hart_cmd, 1);
        @(negedge clk);
        chk("t1_req_c2", bus.hart_cmd_req, 1);
        @(negedge clk);
        chk("t1_req_c3", bus.hart_cmd_req, 1);
        bus.hart_cmd_ack = 1'b1;
        @(negedge clk);
        bus.hart_cmd_ack = 1'b0;
        bus.hart_halted = 1'b1;
        chk("t1_req_drop", bus.hart_cmd_req, 0);
        chk("t1_rsp_vld", bus.host_rsp_vld, 1);
        chk("t1_status", bus.host_rsp_status, 0);
        @(negedge clk);
        chk("t1_rsp_pulse", bus.host_rsp_vld, 0);
        chk("t1_rdy", bus.host_cmd_rdy, 1);

        // HALT on a halted hart, nacked
        send(HALT, 32'h0, 32'h0, 1'b0);
        chk("t2_req", bus.hart_cmd_req, 1);
        bus.hart_cmd_nack = 1'b1;
        @(negedge clk);
        bus.hart_cmd_nack = 1'b0;
        chk("t2_req_drop", bus.hart_cmd_req, 0);
        chk("t2_rsp_vld", bus.host_rsp_vld, 1);
        chk("t2_status", bus.host_rsp_status, 1);
        @(negedge clk);
        chk("t2_rsp_pulse", bus.host_rsp_vld, 0);
        chk("t2_rdy", bus.host_cmd_rdy, 1);

        // EXEC, core writes DDR on re-halt
        send(EXEC, 32'h7B202573, 32'hCAFE0001, 1'b1);
        chk("t3_fetch", bus.hart_fetch_dbgc, 1);
        chk("t3_sstep", bus.hart_sstep_en, 1);
        chk("t3_irq", bus.hart_irq_dsbl, 1);
        chk("t3_instr", bus.hart_instr, 32'h7B202573);
        chk("t3_dreg_out", bus.hart_dreg_out, 32'hCAFE0001);
        chk("t3_hart_cmd", bus.hart_cmd, 0);
        bus.hart_cmd_ack = 1'b1;
        @(negedge clk);
        bus.hart_cmd_ack = 1'b0;
        bus.hart_halted = 1'b0;
        chk("t3_req_drop", bus.hart_cmd_req, 0);
        bus.host_cmd_vld = 1'b1;
        bus.host_cmd = HALT;
        @(negedge clk);
        bus.host_cmd_vld = 1'b0;
        chk("t3_busy_ignored", bus.hart_cmd, 0);
        chk("t3_busy_req", bus.hart_cmd_req, 0);
        bus.hart_halted = 1'b1;
        bus.hart_dreg_wr = 1'b1;
        bus.hart_dreg_in = 32'h1234;
        @(negedge clk);
        bus.hart_dreg_wr = 1'b0;
        chk("t3_rsp_vld", bus.host_rsp_vld, 1);
        chk("t3_status", bus.host_rsp_status, 0);
        chk("t3_rsp_ddr", bus.host_rsp_ddr, 32'h1234);
        chk("t3_fetch_in_rsp", bus.hart_fetch_dbgc, 1);
        @(negedge clk);
        chk("t3_fetch_clr", bus.hart_fetch_dbgc, 0);
        chk("t3_sstep_clr", bus.hart_sstep_en, 0);
        chk("t3_irq_kept", bus.hart_irq_dsbl, 1);
        chk("t3_rdy", bus.host_cmd_rdy, 1);

        // STEP that re-halts with an exception
        send(STEP, 32'h0, 32'h0, 1'b0);
        chk("t4_sstep", bus.hart_sstep_en, 1);
        chk("t4_fetch", bus.hart_fetch_dbgc, 0);
        chk("t4_irq", bus.hart_irq_dsbl, 0);
        bus.hart_cmd_ack = 1'b1;
        @(negedge clk);
        bus.hart_cmd_ack = 1'b0;
        bus.hart_halted = 1'b0;
        @(negedge clk);
        bus.hart_halted = 1'b1;
        bus.hart_except = 1'b1;
        @(negedge clk);
        bus.hart_except = 1'b0;
        chk("t4_rsp_vld", bus.host_rsp_vld, 1);
        chk("t4_status", bus.host_rsp_status, 3);
        chk("t4_ddr_persist", bus.host_rsp_ddr, 32'h1234);
        @(negedge clk);
        chk("t4_sstep_clr", bus.hart_sstep_en, 0);
        chk("t4_rdy", bus.host_cmd_rdy, 1);

        // STEP where the hart never comes back
        send(STEP, 32'h0, 32'h0, 1'b0);
        bus.hart_cmd_ack = 1'b1;
        @(negedge clk);
        bus.hart_cmd_ack = 1'b0;
        bus.hart_halted = 1'b0;
        repeat (15) @(negedge clk);
        chk("t5_rw_no_req", bus.hart_cmd_req, 0);
        @(negedge clk);
`ifdef SCR1_DBGC_SEQ_TIMEOUT_EN
        chk("t5_fh_req", bus.hart_cmd_req, 1);
        chk("t5_fh_hart_cmd", bus.hart_cmd, 1);
        chk("t5_fh_rdy", bus.host_cmd_rdy, 0);
        bus.hart_cmd_ack = 1'b1;
        @(negedge clk);
        bus.hart_cmd_ack = 1'b0;
        chk("t5_fh_req_drop", bus.hart_cmd_req, 0);
        chk("t5_fh_wait", bus.host_rsp_vld, 0);
        bus.hart_halted = 1'b1;
        @(negedge clk);
        chk("t5_rsp_vld", bus.host_rsp_vld, 1);
        chk("t5_status", bus.host_rsp_status, 2);
        @(negedge clk);
        chk("t5_rdy", bus.host_cmd_rdy, 1);
`else
        chk("t5_no_fh_req", bus.hart_cmd_req, 0);
        flag = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.host_rsp_vld || bus.host_cmd_rdy) flag = 1'b1;
        end
        chk("t5_no_rsp", flag, 0);
        bus.hart_halted = 1'b1;
        @(negedge clk);
        chk("t5_late_rsp", bus.host_rsp_vld, 1);
        chk("t5_late_status", bus.host_rsp_status, 0);
        @(negedge clk);
        chk("t5_rdy", bus.host_cmd_rdy, 1);
`endif

        // reset while a request is outstanding
        send(HALT, 32'h0, 32'h0, 1'b0);
        chk("t6_req", bus.hart_cmd_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_req_async", bus.hart_cmd_req, 0);
        chk("t6_rdy_rst", bus.host_cmd_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.host_rsp_vld) flag = 1'b1;
        end
        chk("t6_no_rsp", flag, 0);
        chk("t6_rdy", bus.host_cmd_rdy, 1);
        chk("t6_req_idle", bus.hart_cmd_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
